// File: rtl/cpu_defs_pkg.sv
// Shared CPU definitions: register-address width and the forwarding-select
// encodings used by the EX operand muxes.
package cpu_defs;

    localparam int REG_AW = 5;

    typedef enum logic [1:0] {
        FWD_RF    = 2'b00,
        FWD_EXMEM = 2'b01,
        FWD_MEMWB = 2'b10
    } fwd_sel_e;

endpackage

// File: rtl/sb_slot.sv
// One pipeline-stage slot of the hazard scoreboard: holds {rd, wen, isLoad}.
// A slot with wen=0 is a bubble; writes to x0 are demoted to bubbles on entry.
module sb_slot #(
    parameter int REG_AW = 5
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic [REG_AW-1:0] rdIn,
    input  logic              wenIn,
    input  logic              loadIn,
    output logic [REG_AW-1:0] rdOut,
    output logic              wenOut,
    output logic              loadOut
);

    logic [REG_AW-1:0] rd_q, rd_d;
    logic              wen_q, wen_d;
    logic              load_q, load_d;

    always_comb begin
        rd_d   = rdIn;
        wen_d  = wenIn && (rdIn != '0);
        load_d = loadIn;
    end

    always_ff @(negedge CLK) begin
        if (RST) begin
            rd_q   <= '0;
            wen_q  <= 1'b0;
            load_q <= 1'b0;
        end else begin
            rd_q   <= rd_d;
            wen_q  <= wen_d;
            load_q <= load_d;
        end
    end

    assign rdOut   = rd_q;
    assign wenOut  = wen_q;
    assign loadOut = load_q;

endmodule

// File: rtl/hazard_scoreboard.sv
// Load-use stall detection and EX operand forwarding selects for a 5-stage
// pipeline whose registers update on the falling clock edge.
module hazard_scoreboard #(
    parameter int REG_AW = cpu_defs::REG_AW,
    parameter int CNT_W  = 16
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              issueValid,
    input  logic [REG_AW-1:0] rs1In,
    input  logic [REG_AW-1:0] rs2In,
    input  logic              useRs1,
    input  logic              useRs2,
    input  logic [REG_AW-1:0] rdIn,
    input  logic              wbIn,
    input  logic              loadIn,
    input  logic              flush,
    output logic              stall,
    output logic [1:0]        fwdA,
    output logic [1:0]        fwdB,
    output logic [CNT_W-1:0]  stallCount
);

    import cpu_defs::*;

    logic [REG_AW-1:0] exRd, memRd, wbRd;
    logic              exWen, memWen, wbWen;
    logic              exLoad, memLoad, wbLoad;
    logic              capture;
    logic              wbSlotUnused;

    fwd_sel_e          fwdA_q, fwdA_d;
    fwd_sel_e          fwdB_q, fwdB_d;
    logic [CNT_W-1:0]  stallCount_q, stallCount_d;

    // A load still in EX cannot forward yet, so a dependent instruction waits a cycle.
    assign stall = !flush && issueValid && exWen && exLoad &&
                   ((useRs1 && rs1In == exRd) || (useRs2 && rs2In == exRd));

    assign capture = issueValid && !stall && !flush;

    sb_slot #(.REG_AW(REG_AW)) u_exSlot (
        .CLK     (CLK),
        .RST     (RST),
        .rdIn    (rdIn),
        .wenIn   (capture && wbIn),
        .loadIn  (capture && loadIn),
        .rdOut   (exRd),
        .wenOut  (exWen),
        .loadOut (exLoad)
    );

    sb_slot #(.REG_AW(REG_AW)) u_memSlot (
        .CLK     (CLK),
        .RST     (RST),
        .rdIn    (exRd),
        .wenIn   (exWen),
        .loadIn  (exLoad),
        .rdOut   (memRd),
        .wenOut  (memWen),
        .loadOut (memLoad)
    );

    sb_slot #(.REG_AW(REG_AW)) u_wbSlot (
        .CLK     (CLK),
        .RST     (RST),
        .rdIn    (memRd),
        .wenIn   (memWen),
        .loadIn  (memLoad),
        .rdOut   (wbRd),
        .wenOut  (wbWen),
        .loadOut (wbLoad)
    );

    // WB retires into the register file, which is written before it is read.
    assign wbSlotUnused = ^{wbRd, wbWen, wbLoad};

    always_comb begin
        fwdA_d       = FWD_RF;
        fwdB_d       = FWD_RF;
        stallCount_d = stallCount_q;
        if (capture) begin
            if (useRs1 && exWen && exRd == rs1In)
                fwdA_d = FWD_EXMEM;
            else if (useRs1 && memWen && memRd == rs1In)
                fwdA_d = FWD_MEMWB;
            if (useRs2 && exWen && exRd == rs2In)
                fwdB_d = FWD_EXMEM;
            else if (useRs2 && memWen && memRd == rs2In)
                fwdB_d = FWD_MEMWB;
        end
        if (stall && stallCount_q != '1)
            stallCount_d = stallCount_q + CNT_W'(1);
    end

    always_ff @(negedge CLK) begin
        if (RST) begin
            fwdA_q       <= FWD_RF;
            fwdB_q       <= FWD_RF;
            stallCount_q <= '0;
        end else begin
            fwdA_q       <= fwdA_d;
            fwdB_q       <= fwdB_d;
            stallCount_q <= stallCount_d;
        end
    end

    assign fwdA       = fwdA_q;
    assign fwdB       = fwdB_q;
    assign stallCount = stallCount_q;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Self-checking bench for hazard_scoreboard: a table of per-cycle vectors
// with expected results queued at drive time and compared after each falling edge.
module tb_hazard_scoreboard;

    typedef struct {
        int         tag;
        logic       rst;
        logic       iv;
        logic [4:0] rs1;
        logic       u1;
        logic [4:0] rs2;
        logic       u2;
        logic [4:0] rd;
        logic       wb;
        logic       ld;
        logic       fl;
        logic       expStall;
        logic [1:0] expA;
        logic [1:0] expB;
        logic [15:0] expCnt;
        logic [3:0] expSat;
    } vec_t;

    logic        CLK;
    logic        RST;
    logic        issueValid;
    logic [4:0]  rs1In;
    logic [4:0]  rs2In;
    logic        useRs1;
    logic        useRs2;
    logic [4:0]  rdIn;
    logic        wbIn;
    logic        loadIn;
    logic        flush;
    logic        stall;
    logic [1:0]  fwdA;
    logic [1:0]  fwdB;
    logic [15:0] stallCount;
    logic        satStall;
    logic [1:0]  satFwdA;
    logic [1:0]  satFwdB;
    logic [3:0]  satCount;

    int checks;
    int failures;
    vec_t sbQ[$];
    vec_t vecs[29];

    hazard_scoreboard #(.REG_AW(5), .CNT_W(16)) dut (
        .CLK        (CLK),
        .RST        (RST),
        .issueValid (issueValid),
        .rs1In      (rs1In),
        .rs2In      (rs2In),
        .useRs1     (useRs1),
        .useRs2     (useRs2),
        .rdIn       (rdIn),
        .wbIn       (wbIn),
        .loadIn     (loadIn),
        .flush      (flush),
        .stall      (stall),
        .fwdA       (fwdA),
        .fwdB       (fwdB),
        .stallCount (stallCount)
    );

    // Narrow counter instance so saturation is reachable in a few cycles.
    hazard_scoreboard #(.REG_AW(5), .CNT_W(4)) dutSat (
        .CLK        (CLK),
        .RST        (RST),
        .issueValid (issueValid),
        .rs1In      (rs1In),
        .rs2In      (rs2In),
        .useRs1     (useRs1),
        .useRs2     (useRs2),
        .rdIn       (rdIn),
        .wbIn       (wbIn),
        .loadIn     (loadIn),
        .flush      (flush),
        .stall      (satStall),
        .fwdA       (satFwdA),
        .fwdB       (satFwdB),
        .stallCount (satCount)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    function automatic vec_t mk(input int tag, input logic rst, input logic iv,
                                input int rs1, input logic u1, input int rs2, input logic u2,
                                input int rd, input logic wb, input logic ld, input logic fl,
                                input logic st, input int a, input int b, input int cnt,
                                input int sat);
        vec_t v;
        v.tag      = tag;
        v.rst      = rst;
        v.iv       = iv;
        v.rs1      = rs1[4:0];
        v.u1       = u1;
        v.rs2      = rs2[4:0];
        v.u2       = u2;
        v.rd       = rd[4:0];
        v.wb       = wb;
        v.ld       = ld;
        v.fl       = fl;
        v.expStall = st;
        v.expA     = a[1:0];
        v.expB     = b[1:0];
        v.expCnt   = cnt[15:0];
        v.expSat   = sat[3:0];
        return v;
    endfunction

    // Compare registered outputs against the oldest queued expectation.
    task automatic checkOutput();
        vec_t e;
        if (sbQ.size() == 0) begin
            failures++;
            checks++;
            $display("[TB] FAIL scoreboard: got empty queue, expected a pending vector");
            return;
        end
        e = sbQ.pop_front();
        checks++;
        if (fwdA !== e.expA) begin
            failures++;
            $display("[TB] FAIL fwdA step %0d: got %0d, expected %0d", e.tag, fwdA, e.expA);
        end
        checks++;
        if (fwdB !== e.expB) begin
            failures++;
            $display("[TB] FAIL fwdB step %0d: got %0d, expected %0d", e.tag, fwdB, e.expB);
        end
        checks++;
        if (stallCount !== e.expCnt) begin
            failures++;
            $display("[TB] FAIL stallCount step %0d: got %0d, expected %0d", e.tag, stallCount, e.expCnt);
        end
        checks++;
        if (satCount !== e.expSat) begin
            failures++;
            $display("[TB] FAIL satCount step %0d: got %0d, expected %0d", e.tag, satCount, e.expSat);
        end
    endtask

    // Drive one cycle of inputs, check the combinational stall, then the registered results.
    task automatic applyStimulus(input vec_t v);
        @(posedge CLK);
        RST        = v.rst;
        issueValid = v.iv;
        rs1In      = v.rs1;
        useRs1     = v.u1;
        rs2In      = v.rs2;
        useRs2     = v.u2;
        rdIn       = v.rd;
        wbIn       = v.wb;
        loadIn     = v.ld;
        flush      = v.fl;
        sbQ.push_back(v);
        #1;
        checks++;
        if (stall !== v.expStall) begin
            failures++;
            $display("[TB] FAIL stall step %0d: got %0d, expected %0d", v.tag, stall, v.expStall);
        end
        @(negedge CLK);
        #1;
        checkOutput();
    endtask

    initial begin
        checks     = 0;
        failures   = 0;
        RST        = 1'b1;
        issueValid = 1'b0;
        rs1In      = '0;
        rs2In      = '0;
        useRs1     = 1'b0;
        useRs2     = 1'b0;
        rdIn       = '0;
        wbIn       = 1'b0;
        loadIn     = 1'b0;
        flush      = 1'b0;
        repeat (2) @(negedge CLK);

        //               tag rst iv rs1 u1 rs2 u2 rd wb ld fl  st A  B  cnt sat
        vecs[0]  = mk( 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        vecs[1]  = mk( 1, 0, 1, 0, 0, 0, 0, 5, 1, 0, 0, 0, 0, 0, 0, 0);
        vecs[2]  = mk( 2, 0, 1, 5, 1, 6, 1, 6, 1, 0, 0, 0, 1, 0, 0, 0);
        vecs[3]  = mk( 3, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        vecs[4]  = mk( 4, 0, 1, 0, 0, 0, 0, 5, 1, 0, 0, 0, 0, 0, 0, 0);
        vecs[5]  = mk( 5, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        vecs[6]  = mk( 6, 0, 1, 0, 0, 5, 1, 0, 0, 0, 0, 0, 0, 2, 0, 0);
        vecs[7]  = mk( 7, 0, 1, 0, 0, 0, 0, 5, 1, 0, 0, 0, 0, 0, 0, 0);
        vecs[8]  = mk( 8, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        vecs[9]  = mk( 9, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        vecs[10] = mk(10, 0, 1, 5, 1, 5, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        vecs[11] = mk(11, 0, 1, 0, 0, 0, 0, 7, 1, 1, 0, 0, 0, 0, 0, 0);
        vecs[12] = mk(12, 0, 1, 7, 1, 0, 0, 8, 1, 0, 0, 1, 0, 0, 1, 1);
        vecs[13] = mk(13, 0, 1, 7, 1, 0, 0, 8, 1, 0, 0, 0, 2, 0, 1, 1);
        vecs[14] = mk(14, 0, 1, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 1, 1);
        vecs[15] = mk(15, 0, 1, 0, 1, 0, 1, 9, 0, 0, 0, 0, 0, 0, 1, 1);
        vecs[16] = mk(16, 0, 1, 0, 0, 0, 0, 3, 1, 1, 0, 0, 0, 0, 1, 1);
        vecs[17] = mk(17, 0, 1, 3, 0, 4, 1, 0, 0, 0, 0, 0, 0, 0, 1, 1);
        vecs[18] = mk(18, 0, 1, 0, 0, 0, 0, 7, 1, 1, 0, 0, 0, 0, 1, 1);
        vecs[19] = mk(19, 0, 1, 7, 1, 0, 0, 8, 1, 0, 1, 0, 0, 0, 1, 1);
        vecs[20] = mk(20, 0, 1, 7, 1, 7, 1, 0, 0, 0, 0, 0, 2, 2, 1, 1);
        vecs[21] = mk(21, 0, 1, 0, 0, 0, 0, 5, 1, 0, 0, 0, 0, 0, 1, 1);
        vecs[22] = mk(22, 0, 1, 0, 0, 0, 0, 5, 1, 0, 0, 0, 0, 0, 1, 1);
        vecs[23] = mk(23, 0, 1, 5, 1, 5, 1, 0, 0, 0, 0, 0, 1, 1, 1, 1);
        vecs[24] = mk(24, 0, 1, 0, 0, 0, 0, 7, 1, 1, 0, 0, 0, 0, 1, 1);
        vecs[25] = mk(25, 0, 1, 7, 1, 0, 0, 8, 1, 0, 0, 1, 0, 0, 2, 2);
        vecs[26] = mk(26, 0, 1, 0, 0, 0, 0, 7, 1, 1, 0, 0, 0, 0, 2, 2);
        vecs[27] = mk(27, 1, 1, 7, 1, 0, 0, 8, 1, 0, 0, 1, 0, 0, 0, 0);
        vecs[28] = mk(28, 0, 1, 7, 1, 0, 0, 8, 1, 0, 0, 0, 0, 0, 0, 0);

        for (int i = 0; i < 29; i++)
            applyStimulus(vecs[i]);

        // Repeated load-use pairs drive the 4-bit counter into saturation and hold it there.
        for (int k = 1; k <= 17; k++) begin
            applyStimulus(mk(100 + 2 * k, 0, 1, 0, 0, 0, 0, 7, 1, 1, 0, 0, 0, 0,
                             k - 1, (k - 1 > 15) ? 15 : k - 1));
            applyStimulus(mk(101 + 2 * k, 0, 1, 7, 1, 0, 0, 8, 1, 0, 0, 1, 0, 0,
                             k, (k > 15) ? 15 : k));
        end

        applyStimulus(mk(200, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));

        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule
